tstate_sequencer: RTL and testbench

TSTATE_SEQUENCER -- requirements
Module: tstate_sequencer

---
 rtl/tmp8_pkg.sv | 15 +
 rtl/step_edge_det.sv | 22 ++
 rtl/tstate_sequencer.sv | 106 ++++++++++
 tb/tb_tstate_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/tmp8_pkg.sv
// Shared types and widths for the tmp8 timing/control slice.
// Holds the T-state sequencer state encoding plus step and instruction-counter widths.
package tmp8_pkg;

    localparam int STEP_W = 3;
    localparam int ICNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10,
        PEND = 2'b11
    } tseq_state_t;

endpackage

// File: rtl/step_edge_det.sv
// Rising-edge detector for the already-synchronised single-step button.
// Produces a one-cycle pulse on the cycle the level first goes high.
module step_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic level_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/tstate_sequencer.sv
// T-state sequencer: steps through instruction T-states, counts instructions, takes halts at boundaries.
// Optional single-step debug gating is compiled in with the macro TSEQ_SINGLE_STEP_EN.
module tstate_sequencer
    import tmp8_pkg::*;
#(
    parameter int MAX_STEP = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_en,
    input  logic              stall,
    input  logic              instr_done,
    input  logic              halt_req,
    input  logic              step_mode,
    input  logic              step_btn,
    output logic [STEP_W-1:0] step_o,
    output logic              instr_start_o,
    output logic              halted_o,
    output logic              active_o,
    output logic [ICNT_W-1:0] instr_cnt_o
);

    tseq_state_t state;
    logic        step_gate;
    logic        in_run;
    logic        advance;
    logic        at_last;
    logic        wrap;
    logic        go_halt;

`ifdef TSEQ_SINGLE_STEP_EN
    logic step_pulse;

    step_edge_det u_step_edge_det (
        .clk   (clk),
        .rst   (rst),
        .level (step_btn),
        .pulse (step_pulse)
    );

    assign step_gate = !step_mode || step_pulse;
`else
    logic unused_step_inputs;

    assign unused_step_inputs = step_mode ^ step_btn;
    assign step_gate          = 1'b1;
`endif

    assign in_run  = (state == RUN) || (state == PEND);
    assign advance = in_run && !stall && run_en && step_gate;
    assign at_last = instr_done || (step_o == STEP_W'(MAX_STEP));
    assign wrap    = advance && at_last;

    // A pending halt waits for the instruction boundary; a direct halt needs instr_done alongside it.
    assign go_halt = ((state == RUN) && halt_req && instr_done) ||
                     ((state == PEND) && at_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            step_o        <= '0;
            instr_start_o <= 1'b0;
            halted_o      <= 1'b0;
            active_o      <= 1'b0;
            instr_cnt_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    step_o        <= '0;
                    instr_start_o <= run_en;
                    if (run_en) begin
                        state    <= RUN;
                        active_o <= 1'b1;
                    end
                end
                RUN, PEND: begin
                    instr_start_o <= wrap;
                    if (advance) begin
                        step_o <= wrap ? '0 : step_o + STEP_W'(1);
                    end
                    if (wrap) begin
                        instr_cnt_o <= instr_cnt_o + ICNT_W'(1);
                    end
                    // Halt entry overrides the step and start updates made above.
                    if (go_halt) begin
                        state         <= HALT;
                        halted_o      <= 1'b1;
                        active_o      <= 1'b0;
                        step_o        <= '0;
                        instr_start_o <= 1'b0;
                    end else if ((state == RUN) && halt_req) begin
                        state <= PEND;
                    end
                end
                HALT: begin
                    step_o        <= '0;
                    instr_start_o <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tstate_sequencer.sv
// Scoreboard bench for tstate_sequencer: directed vectors push expected outputs, a monitor pops and compares.
// Covers the single-step path when TSEQ_SINGLE_STEP_EN is defined.
module tb_tstate_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_en;
    logic        stall;
    logic        instr_done;
    logic        halt_req;
    logic        step_mode;
    logic        step_btn;
    logic [2:0]  step_o;
    logic        instr_start_o;
    logic        halted_o;
    logic        active_o;
    logic [15:0] instr_cnt_o;

    typedef struct {
        int          due;
        string       name;
        logic [2:0]  step;
        logic        start;
        logic        halted;
        logic        active;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   fails  = 0;

    tstate_sequencer #(.MAX_STEP(7)) dut (
        .clk           (clk),
        .rst           (rst),
        .run_en        (run_en),
        .stall         (stall),
        .instr_done    (instr_done),
        .halt_req      (halt_req),
        .step_mode     (step_mode),
        .step_btn      (step_btn),
        .step_o        (step_o),
        .instr_start_o (instr_start_o),
        .halted_o      (halted_o),
        .active_o      (active_o),
        .instr_cnt_o   (instr_cnt_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Drive one cycle of inputs and queue what the outputs must be after the next rising edge.
    task automatic applyStimulus(input string name, input logic r, input logic re, input logic st,
                                 input logic dn, input logic hr, input logic sm, input logic sb,
                                 input logic chk, input logic [2:0] es, input logic ess,
                                 input logic eh, input logic ea, input logic [15:0] ec);
        exp_t e;
        rst        = r;
        run_en     = re;
        stall      = st;
        instr_done = dn;
        halt_req   = hr;
        step_mode  = sm;
        step_btn   = sb;
        if (chk) begin
            e.due    = cyc + 1;
            e.name   = name;
            e.step   = es;
            e.start  = ess;
            e.halted = eh;
            e.active = ea;
            e.cnt    = ec;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (step_o !== e.step || instr_start_o !== e.start || halted_o !== e.halted ||
            active_o !== e.active || instr_cnt_o !== e.cnt) begin
            fails++;
            $display("[TB] FAIL %s @cyc %0d: got step=%0d start=%0b halted=%0b active=%0b cnt=%h, want step=%0d start=%0b halted=%0b active=%0b cnt=%h",
                     e.name, cyc, step_o, instr_start_o, halted_o, active_o, instr_cnt_o,
                     e.step, e.start, e.halted, e.active, e.cnt);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            checkOutput(exp_q.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset and idle
        applyStimulus("reset",     1, 0, 0, 0, 0, 0, 0, 1, 3'd0, 0, 0, 0, 16'h0000);
        applyStimulus("idle_hold", 0, 0, 0, 0, 0, 0, 0, 1, 3'd0, 0, 0, 0, 16'h0000);

        // Free run through a full instruction with wrap at MAX_STEP
        applyStimulus("start", 0, 1, 0, 0, 0, 0, 0, 1, 3'd0, 1, 0, 1, 16'h0000);
        for (int k = 1; k <= 7; k++)
            applyStimulus("walk", 0, 1, 0, 0, 0, 0, 0, 1, 3'(k), 0, 0, 1, 16'h0000);
        applyStimulus("wrap_max", 0, 1, 0, 0, 0, 0, 0, 1, 3'd0, 1, 0, 1, 16'h0001);

        // Early completion via instr_done at step 4
        for (int k = 1; k <= 4; k++)
            applyStimulus("walk", 0, 1, 0, 0, 0, 0, 0, 1, 3'(k), 0, 0, 1, 16'h0001);
        applyStimulus("done_at4", 0, 1, 0, 1, 0, 0, 0, 1, 3'd0, 1, 0, 1, 16'h0002);

        // Stall and run_en gating
        for (int k = 1; k <= 2; k++)
            applyStimulus("walk", 0, 1, 0, 0, 0, 0, 0, 1, 3'(k), 0, 0, 1, 16'h0002);
        for (int k = 0; k < 3; k++)
            applyStimulus("stall", 0, 1, 1, 0, 0, 0, 0, 1, 3'd2, 0, 0, 1, 16'h0002);
        applyStimulus("unstall",    0, 1, 0, 0, 0, 0, 0, 1, 3'd3, 0, 0, 1, 16'h0002);
        applyStimulus("run_off",    0, 0, 0, 0, 0, 0, 0, 1, 3'd3, 0, 0, 1, 16'h0002);
        applyStimulus("run_on",     0, 1, 0, 0, 0, 0, 0, 1, 3'd4, 0, 0, 1, 16'h0002);
        applyStimulus("stall_done", 0, 1, 1, 1, 0, 0, 0, 1, 3'd4, 0, 0, 1, 16'h0002);

        // Single-step mode (or its absence)
        applyStimulus("reset", 1, 0, 0, 0, 0, 0, 0, 1, 3'd0, 0, 0, 0, 16'h0000);
        applyStimulus("start", 0, 1, 0, 0, 0, 0, 0, 1, 3'd0, 1, 0, 1, 16'h0000);
`ifdef TSEQ_SINGLE_STEP_EN
        for (int k = 0; k < 2; k++)
            applyStimulus("ss_idle", 0, 1, 0, 0, 0, 1, 0, 1, 3'd0, 0, 0, 1, 16'h0000);
        applyStimulus("ss_press1", 0, 1, 0, 0, 0, 1, 1, 1, 3'd1, 0, 0, 1, 16'h0000);
        for (int k = 0; k < 9; k++)
            applyStimulus("ss_held", 0, 1, 0, 0, 0, 1, 1, 1, 3'd1, 0, 0, 1, 16'h0000);
        applyStimulus("ss_rel1",   0, 1, 0, 0, 0, 1, 0, 1, 3'd1, 0, 0, 1, 16'h0000);
        applyStimulus("ss_press2", 0, 1, 0, 0, 0, 1, 1, 1, 3'd2, 0, 0, 1, 16'h0000);
        applyStimulus("ss_rel2",   0, 1, 0, 0, 0, 1, 0, 1, 3'd2, 0, 0, 1, 16'h0000);
        applyStimulus("ss_press3", 0, 1, 0, 0, 0, 1, 1, 1, 3'd3, 0, 0, 1, 16'h0000);
        applyStimulus("ss_rel3",   0, 1, 0, 0, 0, 1, 0, 1, 3'd3, 0, 0, 1, 16'h0000);
        applyStimulus("ss_off",    0, 1, 0, 0, 0, 0, 0, 1, 3'd4, 0, 0, 1, 16'h0000);
`else
        for (int k = 1; k <= 4; k++)
            applyStimulus("ss_ignored", 0, 1, 0, 0, 0, 1, 0, 1, 3'(k), 0, 0, 1, 16'h0000);
`endif

        // Halt pending until instruction boundary, then frozen in HALT
        applyStimulus("reset", 1, 0, 0, 0, 0, 0, 0, 1, 3'd0, 0, 0, 0, 16'h0000);
        applyStimulus("start", 0, 1, 0, 0, 0, 0, 0, 1, 3'd0, 1, 0, 1, 16'h0000);
        applyStimulus("walk",  0, 1, 0, 0, 0, 0, 0, 1, 3'd1, 0, 0, 1, 16'h0000);
        applyStimulus("halt_req_at1", 0, 1, 0, 0, 1, 0, 0, 1, 3'd2, 0, 0, 1, 16'h0000);
        for (int k = 3; k <= 5; k++)
            applyStimulus("pend_walk", 0, 1, 0, 0, 0, 0, 0, 1, 3'(k), 0, 0, 1, 16'h0000);
        applyStimulus("pend_done", 0, 1, 0, 1, 0, 0, 0, 1, 3'd0, 0, 1, 0, 16'h0001);
        for (int k = 0; k < 20; k++)
            applyStimulus("halt_hold", 0, 1, 0, k[0], k[1], 0, 0, 1, 3'd0, 0, 1, 0, 16'h0001);

        // Direct halt with instr_done, then reset out of HALT
        applyStimulus("reset", 1, 0, 0, 0, 0, 0, 0, 1, 3'd0, 0, 0, 0, 16'h0000);
        applyStimulus("start", 0, 1, 0, 0, 0, 0, 0, 1, 3'd0, 1, 0, 1, 16'h0000);
        applyStimulus("walk",  0, 1, 0, 0, 0, 0, 0, 1, 3'd1, 0, 0, 1, 16'h0000);
        applyStimulus("halt_direct", 0, 1, 0, 1, 1, 0, 0, 1, 3'd0, 0, 1, 0, 16'h0001);
        applyStimulus("halt_hold",   0, 1, 0, 0, 0, 0, 0, 1, 3'd0, 0, 1, 0, 16'h0001);
        applyStimulus("reset_from_halt", 1, 1, 0, 0, 0, 0, 0, 1, 3'd0, 0, 0, 0, 16'h0000);

        // Counter to FFFF, then wrap to 0000
        applyStimulus("start", 0, 1, 0, 0, 0, 0, 0, 1, 3'd0, 1, 0, 1, 16'h0000);
        for (int i = 0; i < 65535; i++)
            applyStimulus("cnt_ffff", 0, 1, 0, 1, 0, 0, 0, (i == 65534), 3'd0, 1, 0, 1, 16'hFFFF);
        for (int k = 1; k <= 6; k++)
            applyStimulus("walk_ffff", 0, 1, 0, 0, 0, 0, 0, 1, 3'(k), 0, 0, 1, 16'hFFFF);
        applyStimulus("cnt_wrap", 0, 1, 0, 1, 0, 0, 0, 1, 3'd0, 1, 0, 1, 16'h0000);

        // Reset mid-instruction with a pending halt discards everything
        for (int k = 1; k <= 3; k++)
            applyStimulus("walk", 0, 1, 0, 0, 0, 0, 0, 1, 3'(k), 0, 0, 1, 16'h0000);
        applyStimulus("halt_pend", 0, 1, 0, 0, 1, 0, 0, 1, 3'd4, 0, 0, 1, 16'h0000);
        applyStimulus("reset_mid", 1, 1, 0, 1, 0, 0, 0, 1, 3'd0, 0, 0, 0, 16'h0000);
        applyStimulus("start", 0, 1, 0, 0, 0, 0, 0, 1, 3'd0, 1, 0, 1, 16'h0000);
        for (int k = 1; k <= 7; k++)
            applyStimulus("walk_nohalt", 0, 1, 0, 0, 0, 0, 0, 1, 3'(k), 0, 0, 1, 16'h0000);
        applyStimulus("wrap_nohalt", 0, 1, 0, 0, 0, 0, 0, 1, 3'd0, 1, 0, 1, 16'h0001);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            fails++;
            $display("[TB] FAIL %s: got no sample, want a compared output", e.name);
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
